fir_stream_controller: RTL

FIR_STREAM_CONTROLLER -- requirements
Module: fir_stream_controller

---
 rtl/fir_stream_controller_if.sv | 44 ++++
 rtl/fir_stream_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fir_stream_controller_if.sv
// rtl/fir_stream_controller_if.sv - stream, config and datapath signals of the FIR stream controller
interface fir_stream_controller_if #(
    parameter int MAX_TAPS = 16
) ();
    localparam int TW = $clog2(MAX_TAPS);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [TW-1:0] cfg_taps;
    logic          coeff_in_valid;
    logic          coeff_in_ready;
    logic [31:0]   coeff_in_data;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          dp_rstn;
    logic [TW-1:0] tap_count;
    logic          coeff_data_valid;
    logic [31:0]   coeff_data;
    logic          input_data_valid;
    logic [31:0]   input_data;
    logic          compute;
    logic [31:0]   output_data;
    logic          output_data_valid;
    logic          coefficient_loading_complete;
    logic          busy;

    modport master (
        input  cfg_valid, cfg_taps, coeff_in_valid, coeff_in_data, s_valid, s_data, m_ready,
               output_data, output_data_valid, coefficient_loading_complete,
        output cfg_ready, coeff_in_ready, s_ready, m_valid, m_data, dp_rstn, tap_count,
               coeff_data_valid, coeff_data, input_data_valid, input_data, compute, busy
    );

    modport slave (
        output cfg_valid, cfg_taps, coeff_in_valid, coeff_in_data, s_valid, s_data, m_ready,
               output_data, output_data_valid, coefficient_loading_complete,
        input  cfg_ready, coeff_in_ready, s_ready, m_valid, m_data, dp_rstn, tap_count,
               coeff_data_valid, coeff_data, input_data_valid, input_data, compute, busy
    );
endinterface

// File: rtl/fir_stream_controller.sv
// rtl/fir_stream_controller.sv - sequences tap config, coefficient load and sample streaming
// around an external FIR datapath, buffering its results in a small output FIFO.
module fir_stream_controller #(
    parameter int MAX_TAPS  = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fir_stream_controller_if.master bus
);
    localparam int TW = $clog2(MAX_TAPS);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tap_count_q, tap_count_d;
    logic [TW-1:0] coeff_cnt_q, coeff_cnt_d;
    logic          dp_rstn_q, dp_rstn_d;
    logic          coeff_valid_q, coeff_valid_d;
    logic [31:0]   coeff_data_q, coeff_data_d;
    logic          in_valid_q, in_valid_d;
    logic [31:0]   in_data_q, in_data_d;
    logic          pend_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [31:0]   fifo_mem_q [OUT_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;
    logic [CW:0]   occupancy;
    logic          cfg_hs, coeff_hs, s_hs, push, pop;
    logic          unused_loading_complete;

    assign unused_loading_complete = bus.coefficient_loading_complete;

    // Results still in the datapath reserve FIFO space, so a push can never find it full.
    assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};

    assign bus.s_ready        = (state_q == RUN) && (occupancy < (CW+1)'(OUT_DEPTH));
    assign bus.coeff_in_ready = (state_q == LOAD);
    assign s_hs               = bus.s_valid && bus.s_ready;
    assign bus.cfg_ready      = (state_q == IDLE) ||
                                ((state_q == RUN) && (inflight_q == '0) && (fifo_cnt_q == '0) && !s_hs);
    assign cfg_hs             = bus.cfg_valid && bus.cfg_ready;
    assign coeff_hs           = bus.coeff_in_valid && bus.coeff_in_ready;

    // The datapath answers two cycles after the handshake; warm-up results arrive invalid.
    assign push = pend_q && bus.output_data_valid;
    assign pop  = bus.m_valid && bus.m_ready;

    always_comb begin
        state_d       = state_q;
        tap_count_d   = tap_count_q;
        coeff_cnt_d   = coeff_cnt_q;
        dp_rstn_d     = 1'b1;
        coeff_valid_d = 1'b0;
        coeff_data_d  = coeff_data_q;
        in_valid_d    = 1'b0;
        in_data_d     = in_data_q;
        inflight_d    = inflight_q + CW'(s_hs) - CW'(pend_q);
        if (cfg_hs) begin
            tap_count_d = (bus.cfg_taps == '0) ? TW'(1) : bus.cfg_taps;
            coeff_cnt_d = '0;
            dp_rstn_d   = 1'b0;
            state_d     = LOAD;
        end
        if (coeff_hs) begin
            coeff_valid_d = 1'b1;
            coeff_data_d  = bus.coeff_in_data;
            coeff_cnt_d   = coeff_cnt_q + TW'(1);
            if (coeff_cnt_q == tap_count_q - TW'(1)) begin
                state_d = RUN;
            end
        end
        if (s_hs) begin
            in_valid_d = 1'b1;
            in_data_d  = bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tap_count_q   <= '0;
            coeff_cnt_q   <= '0;
            dp_rstn_q     <= 1'b0;
            coeff_valid_q <= 1'b0;
            coeff_data_q  <= '0;
            in_valid_q    <= 1'b0;
            in_data_q     <= '0;
            pend_q        <= 1'b0;
            inflight_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            tap_count_q   <= tap_count_d;
            coeff_cnt_q   <= coeff_cnt_d;
            dp_rstn_q     <= dp_rstn_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_data_q  <= coeff_data_d;
            in_valid_q    <= in_valid_d;
            in_data_q     <= in_data_d;
            pend_q        <= in_valid_q;
            inflight_q    <= inflight_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.output_data;
        end
    end

    assign bus.m_valid          = (fifo_cnt_q != '0);
    assign bus.m_data           = bus.m_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign bus.dp_rstn          = dp_rstn_q;
    assign bus.tap_count        = tap_count_q;
    assign bus.coeff_data_valid = coeff_valid_q;
    assign bus.coeff_data       = coeff_data_q;
    assign bus.input_data_valid = in_valid_q;
    assign bus.input_data       = in_data_q;
    assign bus.compute          = in_valid_q;
    assign bus.busy             = (state_q != IDLE);
endmodule
